// File: rtl/tri_pipe_scheduler.sv
// Sequencer for triangle_pipe: snoops triangle FIFO occupancy, issues start pulses
// when a whole triangle is buffered, counts completions per frame, aborts hung frames.
module tri_pipe_scheduler #(
   parameter int CNT_WIDTH      = 8,
   parameter int TRI_WIDTH      = 16,
   parameter int TIMEOUT_CYCLES = 10000
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 frame_start,
   input  logic [TRI_WIDTH-1:0] num_tris,
   input  logic [3:0]           vertexSize,
   input  logic                 tri_wr,
   input  logic                 tri_rd,
   input  logic                 frag_fifo_threshold,
   input  logic                 pipe_ready,
   input  logic                 pipe_done,
   output logic                 pipe_start,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 timeout_err,
   output logic [TRI_WIDTH-1:0] tris_issued,
   output logic [CNT_WIDTH-1:0] occupancy
);

   localparam int WD_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_WIDTH-1:0] WD_LIMIT = WD_WIDTH'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_START,
      S_RUN,
      S_FIN
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] occ_q, occ_d;
   logic [CNT_WIDTH-1:0] tri_words_q, tri_words_d;
   logic [TRI_WIDTH-1:0] target_q, target_d;
   logic [TRI_WIDTH-1:0] issued_q, issued_d;
   logic [WD_WIDTH-1:0]  wd_q, wd_d;
   logic                 timeout_q, timeout_d;
   logic                 pipe_start_q, pipe_start_d;
   logic                 frame_done_q, frame_done_d;
   logic                 busy_q, busy_d;

   logic [CNT_WIDTH-1:0] tri_words_calc;
   logic                 launch_ok;

   assign tri_words_calc = CNT_WIDTH'(3 * (32'(vertexSize) + 32'd1));
   assign launch_ok      = (occ_q >= tri_words_q) && !frag_fifo_threshold && pipe_ready;

   // Simultaneous write and read leave the count unchanged; both ends saturate.
   always_comb begin
      occ_d = occ_q;
      if (tri_wr && !tri_rd && (occ_q != {CNT_WIDTH{1'b1}})) begin
         occ_d = occ_q + 1'b1;
      end else if (tri_rd && !tri_wr && (occ_q != '0)) begin
         occ_d = occ_q - 1'b1;
      end
   end

   always_comb begin
      // NOTE: every signal gets a default before the case so no path infers a latch.
      state_d      = state_q;
      tri_words_d  = tri_words_q;
      target_d     = target_q;
      issued_d     = issued_q;
      wd_d         = wd_q;
      timeout_d    = timeout_q;
      frame_done_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (frame_start) begin
               target_d    = num_tris;
               tri_words_d = tri_words_calc;
               issued_d    = '0;
               timeout_d   = 1'b0;
               if (num_tris == '0) begin
                  frame_done_d = 1'b1;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (launch_ok) state_d = S_START;
         end
         S_START: begin
            wd_d    = '0;
            state_d = S_RUN;
         end
         S_RUN: begin
            wd_d = wd_q + 1'b1;
            // A completion in the same cycle as the watchdog expiry is honoured.
            if (pipe_done) begin
               issued_d = issued_q + 1'b1;
               state_d  = (issued_d == target_q) ? S_FIN : S_WAIT;
            end else if (wd_d == WD_LIMIT) begin
               timeout_d    = 1'b1;
               frame_done_d = 1'b1;
               state_d      = S_IDLE;
            end
         end
         S_FIN: begin
            frame_done_d = 1'b1;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      pipe_start_d = (state_d == S_START);
      // Busy spans the frame including the cycle frame_done is shown.
      busy_d       = (state_d != S_IDLE) || (state_q != S_IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= S_IDLE;
         occ_q        <= '0;
         tri_words_q  <= '0;
         target_q     <= '0;
         issued_q     <= '0;
         wd_q         <= '0;
         timeout_q    <= 1'b0;
         pipe_start_q <= 1'b0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         occ_q        <= occ_d;
         tri_words_q  <= tri_words_d;
         target_q     <= target_d;
         issued_q     <= issued_d;
         wd_q         <= wd_d;
         timeout_q    <= timeout_d;
         pipe_start_q <= pipe_start_d;
         frame_done_q <= frame_done_d;
         busy_q       <= busy_d;
      end
   end

   assign pipe_start  = pipe_start_q;
   assign busy        = busy_q;
   assign frame_done  = frame_done_q;
   assign timeout_err = timeout_q;
   assign tris_issued = issued_q;
   assign occupancy   = occ_q;

endmodule

// File: tb/tb_tri_pipe_scheduler.sv
// Self-checking bench for tri_pipe_scheduler: an edge-indexed frame model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_tri_pipe_scheduler;

   localparam int CW = 8;
   localparam int TW = 16;
   localparam int TO = 20;

   logic          clk = 1'b0;
   logic          resetn;
   logic          frame_start = 1'b0;
   logic [TW-1:0] num_tris = '0;
   logic [3:0]    vertexSize = '0;
   logic          tri_wr = 1'b0;
   logic          tri_rd = 1'b0;
   logic          frag_fifo_threshold = 1'b0;
   logic          pipe_ready = 1'b0;
   logic          pipe_done = 1'b0;
   logic          pipe_start;
   logic          busy;
   logic          frame_done;
   logic          timeout_err;
   logic [TW-1:0] tris_issued;
   logic [CW-1:0] occupancy;

   int tests = 0;
   int fails = 0;
   bit cmp_en = 1'b0;
   int start_pulses = 0;
   int done_pulses = 0;

   always #5 clk = ~clk;

   tri_pipe_scheduler #(
      .CNT_WIDTH(CW),
      .TRI_WIDTH(TW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .frame_start(frame_start),
      .num_tris(num_tris),
      .vertexSize(vertexSize),
      .tri_wr(tri_wr),
      .tri_rd(tri_rd),
      .frag_fifo_threshold(frag_fifo_threshold),
      .pipe_ready(pipe_ready),
      .pipe_done(pipe_done),
      .pipe_start(pipe_start),
      .busy(busy),
      .frame_done(frame_done),
      .timeout_err(timeout_err),
      .tris_issued(tris_issued),
      .occupancy(occupancy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Frame model: events are placed on an edge index rather than tracked as FSM states.
   int m_edge = 0;
   int m_occ = 0;
   int m_words = 0;
   int m_target = 0;
   int m_issued = 0;
   int m_start_edge = -1;
   int m_fin_edge = -1;
   int m_wait_from = 0;
   bit m_on = 1'b0;
   bit m_timeout = 1'b0;
   bit exp_start = 1'b0;
   bit exp_done = 1'b0;
   bit exp_busy = 1'b0;

   always @(posedge clk or negedge resetn) begin : model_p
      int old_occ;
      bit was_on;
      bit done_now;
      if (!resetn) begin
         m_occ = 0; m_words = 0; m_target = 0; m_issued = 0;
         m_start_edge = -1; m_fin_edge = -1; m_wait_from = 0;
         m_on = 1'b0; m_timeout = 1'b0;
         exp_start = 1'b0; exp_done = 1'b0; exp_busy = 1'b0;
      end else begin
         m_edge++;
         old_occ   = m_occ;
         was_on    = m_on;
         done_now  = 1'b0;
         exp_start = 1'b0;
         if (tri_wr && !tri_rd) m_occ = (m_occ == 255) ? 255 : m_occ + 1;
         else if (tri_rd && !tri_wr) m_occ = (m_occ == 0) ? 0 : m_occ - 1;

         if (!m_on) begin
            if (frame_start) begin
               m_target  = int'(num_tris);
               m_words   = 3 * (int'(vertexSize) + 1);
               m_issued  = 0;
               m_timeout = 1'b0;
               if (num_tris == '0) done_now = 1'b1;
               else begin
                  m_on        = 1'b1;
                  m_wait_from = m_edge + 1;
               end
            end
         end else if (m_fin_edge == m_edge) begin
            done_now   = 1'b1;
            m_on       = 1'b0;
            m_fin_edge = -1;
         end else if (m_start_edge >= 0) begin
            if (m_edge > m_start_edge + 1) begin
               if (pipe_done) begin
                  m_issued++;
                  m_start_edge = -1;
                  if (m_issued == m_target) m_fin_edge = m_edge + 1;
                  else m_wait_from = m_edge + 1;
               end else if (m_edge == m_start_edge + TO) begin
                  m_timeout    = 1'b1;
                  done_now     = 1'b1;
                  m_on         = 1'b0;
                  m_start_edge = -1;
               end
            end
         end else if (m_fin_edge < 0 && m_edge >= m_wait_from && old_occ >= m_words &&
                      !frag_fifo_threshold && pipe_ready) begin
            m_start_edge = m_edge;
            exp_start    = 1'b1;
         end

         exp_done = done_now;
         exp_busy = m_on || (done_now && was_on);
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("cyc_pipe_start", 32'(pipe_start), 32'(exp_start));
         check("cyc_busy", 32'(busy), 32'(exp_busy));
         check("cyc_frame_done", 32'(frame_done), 32'(exp_done));
         check("cyc_timeout_err", 32'(timeout_err), 32'(m_timeout));
         check("cyc_tris_issued", 32'(tris_issued), 32'(m_issued));
         check("cyc_occupancy", 32'(occupancy), 32'(m_occ));
      end
   end

   always @(posedge clk) begin
      if (pipe_start) start_pulses++;
      if (frame_done) done_pulses++;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic start_frame(input int n, input int vs);
      frame_start = 1'b1;
      num_tris    = TW'(n);
      vertexSize  = 4'(vs);
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   task automatic write_words(input int n);
      tri_wr = 1'b1;
      repeat (n) @(negedge clk);
      tri_wr = 1'b0;
   endtask

   task automatic read_words(input int n);
      tri_rd = 1'b1;
      repeat (n) @(negedge clk);
      tri_rd = 1'b0;
   endtask

   task automatic wait_start(input int budget);
      int w = 0;
      while (!pipe_start && w < budget) begin
         @(negedge clk);
         w++;
      end
      if (!pipe_start) check("wait_pipe_start_bound", 32'(pipe_start), 32'd1);
   endtask

   task automatic wait_frame_done(input int budget, output int waited);
      waited = 0;
      while (!frame_done && waited < budget) begin
         @(negedge clk);
         waited++;
      end
      if (!frame_done) check("wait_frame_done_bound", 32'(frame_done), 32'd1);
   endtask

   task automatic finish_pipe(input int delay);
      int w;
      tick(delay);
      pipe_done = 1'b1;
      @(negedge clk);
      pipe_done = 1'b0;
      wait_frame_done(10, w);
      tick(1);
   endtask

   initial begin
      int s0, f0, w;
      resetn = 1'b1;
      #1 resetn = 1'b0;
      cmp_en = 1'b1;
      tick(3);
      check("reset_outputs", 32'({pipe_start, busy, frame_done, timeout_err, tris_issued, occupancy}), 32'd0);
      resetn     = 1'b1;
      pipe_ready = 1'b1;
      tick(2);

      // One 24-word triangle: the 23rd word must not launch, the 24th must.
      start_frame(1, 7);
      write_words(23);
      check("occ_after_23", 32'(occupancy), 32'd23);
      tick(4);
      check("no_start_at_23", 32'(pipe_start), 32'd0);
      write_words(1);
      check("occ_after_24", 32'(occupancy), 32'd24);
      check("start_not_yet", 32'(pipe_start), 32'd0);
      @(negedge clk);
      check("start_after_24", 32'(pipe_start), 32'd1);
      tick(3);
      pipe_done = 1'b1;
      @(negedge clk);
      pipe_done = 1'b0;
      check("issued_single", 32'(tris_issued), 32'd1);
      @(negedge clk);
      check("fin_done_pulse", 32'(frame_done), 32'd1);
      check("fin_busy_high", 32'(busy), 32'd1);
      @(negedge clk);
      check("fin_busy_low", 32'(busy), 32'd0);
      read_words(24);
      check("drained", 32'(occupancy), 32'd0);

      // Back-pressure holds the start off until it drops.
      start_frame(1, 7);
      frag_fifo_threshold = 1'b1;
      write_words(24);
      s0 = start_pulses;
      tick(50);
      check("thr_no_start", 32'(start_pulses - s0), 32'd0);
      frag_fifo_threshold = 1'b0;
      @(negedge clk);
      check("thr_release_start", 32'(pipe_start), 32'd1);
      finish_pipe(2);
      read_words(24);

      // Two triangles preloaded, pipe completes 10 cycles after each start.
      write_words(48);
      s0 = start_pulses;
      f0 = done_pulses;
      start_frame(2, 7);
      for (int k = 1; k <= 2; k++) begin
         wait_start(20);
         tick(9);
         pipe_done = 1'b1;
         @(negedge clk);
         pipe_done = 1'b0;
         check("issued_step", 32'(tris_issued), 32'(k));
      end
      @(negedge clk);
      check("two_done_pulse", 32'(frame_done), 32'd1);
      check("two_busy_during_done", 32'(busy), 32'd1);
      @(negedge clk);
      check("two_done_end", 32'(frame_done), 32'd0);
      check("two_busy_end", 32'(busy), 32'd0);
      check("two_start_count", 32'(start_pulses - s0), 32'd2);
      check("two_done_count", 32'(done_pulses - f0), 32'd1);
      read_words(48);

      // Occupancy corner cases.
      write_words(5);
      tri_wr = 1'b1;
      tri_rd = 1'b1;
      @(negedge clk);
      tri_wr = 1'b0;
      tri_rd = 1'b0;
      check("occ_wr_rd_same", 32'(occupancy), 32'd5);
      read_words(6);
      check("occ_floor", 32'(occupancy), 32'd0);
      write_words(260);
      check("occ_ceiling", 32'(occupancy), 32'd255);

      // Watchdog abort with no pipe_done.
      start_frame(1, 7);
      wait_start(20);
      wait_frame_done(40, w);
      check("timeout_latency", 32'(w), 32'd20);
      check("timeout_err_set", 32'(timeout_err), 32'd1);
      @(negedge clk);
      check("timeout_idle", 32'(busy), 32'd0);
      tick(3);
      check("timeout_sticky", 32'(timeout_err), 32'd1);
      s0 = start_pulses;
      start_frame(0, 7);
      check("zero_tris_done", 32'(frame_done), 32'd1);
      check("zero_tris_clears_err", 32'(timeout_err), 32'd0);
      @(negedge clk);
      check("zero_tris_done_end", 32'(frame_done), 32'd0);
      check("zero_tris_no_start", 32'(start_pulses - s0), 32'd0);

      // 48-word triangles, then asynchronous reset while running.
      read_words(208);
      start_frame(1, 15);
      tick(3);
      check("vs15_no_start_47", 32'(pipe_start), 32'd0);
      write_words(1);
      @(negedge clk);
      check("vs15_start_48", 32'(pipe_start), 32'd1);
      tick(3);
      #2 resetn = 1'b0;
      #1;
      check("async_reset_outputs", 32'({pipe_start, busy, frame_done, timeout_err, tris_issued, occupancy}), 32'd0);
      check("async_reset_busy", 32'(busy), 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      tick(5);

      cmp_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/tri_pipe_scheduler.md
# tri_pipe_scheduler

Sequencer for `triangle_pipe`. It tracks how many words are in the triangle FIFO and issues a `start` pulse to the pipe only when three things hold: a whole triangle is buffered, the fragment FIFO is below threshold, and the pipe reports ready. It counts completed triangles against a per-frame target and signals frame completion. A watchdog aborts the frame if the pipe hangs. It sits between the vertex-producing front end and `triangle_pipe`, replacing the hand-driven `start` used in bring-up benches.

## Interface
- `CNT_WIDTH`, default 8: width of the triangle FIFO occupancy counter; must cover the FIFO depth.
- `TRI_WIDTH`, default 16: width of the per-frame triangle target and issued count.
- `TIMEOUT_CYCLES`, default 10000: maximum number of RUN cycles allowed before `pipe_done` must arrive.
- `clk`  in  1  single clock; all logic on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `frame_start`  in  1  one-cycle request to begin a frame; honoured only in IDLE.
- `num_tris`  in  TRI_WIDTH  triangles in the frame; latched on an accepted `frame_start`.
- `vertexSize`  in  4  last word index of a vertex (7 means 8 words); sampled on `frame_start`.
- `tri_wr`  in  1  write strobe of the triangle FIFO (snooped).
- `tri_rd`  in  1  read strobe of the triangle FIFO, i.e. the pipe's `tri_fifo_rd_en` (snooped).
- `frag_fifo_threshold`  in  1  back-pressure; while high, no new triangle is started.
- `pipe_ready`  in  1  `triangle_pipe` ready.
- `pipe_done`  in  1  `triangle_pipe` done.
- `pipe_start`  out  1  one-cycle start pulse to `triangle_pipe`.
- `busy`  out  1  high in any state except IDLE.
- `frame_done`  out  1  one-cycle pulse at frame end, normal or aborted.
- `timeout_err`  out  1  sticky; cleared only by reset or an accepted `frame_start`.
- `tris_issued`  out  TRI_WIDTH  triangles completed in the current frame.
- `occupancy`  out  CNT_WIDTH  current triangle FIFO word count.

## Operation
- All outputs are registered.
- Reset value of every output is 0; the state resets to IDLE.
- Triangle size in words: `tri_words = 3*(vertexSize+1)`, computed at `frame_start` and held for the frame. Width is CNT_WIDTH; vertexSize=15 gives 48.
- Occupancy counter, independent of the state machine, always active:
  - `tri_wr` only: +1. `tri_rd` only: −1. Both in the same cycle: unchanged.
  - Saturates at 2^CNT_WIDTH−1 and at 0; a read at 0 leaves 0.
- State machine:
  - **IDLE**: on `frame_start`, latch `num_tris` and `tri_words`, clear `tris_issued` and `timeout_err`.
    - If `num_tris` == 0: pulse `frame_done` next cycle and stay in IDLE.
    - Otherwise go to WAIT.
  - **WAIT**: go to START when all three hold: `occupancy >= tri_words`, `frag_fifo_threshold` == 0, `pipe_ready` == 1.
  - **START**: `pipe_start` = 1 for exactly this one cycle; clear the watchdog; go to RUN.
  - **RUN**: the watchdog increments every cycle.
    - On `pipe_done`: `tris_issued` += 1. If the new value equals the target, go to FIN; otherwise go to WAIT.
    - If the watchdog reaches TIMEOUT_CYCLES−1 without `pipe_done`: set `timeout_err`, pulse `frame_done`, go to IDLE.
    - If `pipe_done` and the timeout occur in the same cycle, `pipe_done` wins.
  - **FIN**: `frame_done` = 1 for one cycle; go to IDLE.
- `frame_start` outside IDLE is ignored. `pipe_done` outside RUN is ignored.
- Asserting reset mid-frame returns the block to IDLE immediately and clears all outputs, including `occupancy`.

## Timing
- WAIT condition true at edge k → `pipe_start` high from edge k to edge k+1 → state is RUN after edge k+1.
- `pipe_done` sampled high at edge m → `tris_issued` updates at edge m. For the last triangle, `frame_done` is high from edge m+1 to edge m+2.
- Minimum spacing between consecutive `pipe_start` pulses: 3 cycles (START, RUN, WAIT).
- `occupancy` reflects a strobe one cycle after it is sampled. The WAIT check uses the registered value, so a triangle that completes at edge k can start at edge k+1 at the earliest.

## Test plan
- `vertexSize`=7, `num_tris`=1, `pipe_ready`=1, 23 `tri_wr` strobes → `pipe_start` stays 0. The 24th strobe → `pipe_start` pulses 1 cycle later, `occupancy`=24.
- Same setup with `frag_fifo_threshold`=1 held for 50 cycles → no `pipe_start`. Drop the threshold → `pipe_start` on the next edge.
- `num_tris`=2, 48 words preloaded, pipe model asserts `pipe_done` 10 cycles after each start → two `pipe_start` pulses; `tris_issued` goes 1 then 2; a single `frame_done`; `busy` falls together with the end of `frame_done`.
- `tri_wr` and `tri_rd` in the same cycle at `occupancy`=5 → stays 5. `tri_rd` at 0 → stays 0.
- `TIMEOUT_CYCLES`=20, `pipe_done` never asserted → `timeout_err`=1 and `frame_done` pulse 20 cycles after `pipe_start`; state returns to IDLE. The next `frame_start` clears `timeout_err`.
- Two cases:
  - `num_tris`=0 → `frame_done` the cycle after `frame_start`, with no `pipe_start`.
  - `resetn` pulsed low during RUN → all outputs 0 asynchronously, and `busy`=0.
